decimator_mc: RTL and testbench

Multi-channel, mode-selectable sample-strobe decimator for the IAGC acquisition path. It generates one-cycle sample strobes per channel, at independent programmable decimation factors, while the IAGC status reports the acquisition running. It adds four gate-handling modes, including a gate-triggered finite burst, and a sample counter. Its strobes feed the downstream ADC capture/accumulation blocks.

---
 rtl/decimator_mc.sv | 176 +++++++++++++++++
 tb/tb_decimator_mc.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/decimator_mc.sv
// Multi-channel sample-strobe decimator with continuous/gated/restart/burst gate modes and a channel-0 strobe counter.
// Latency: first strobe D qualifying edges after LOAD, gate seen 2 edges late; backpressure: none, strobes are free-running.
module decimator_mc #(
    parameter int N_CHANNELS   = 4,
    parameter int NB_DECIMATOR = 8,
    parameter int NB_COUNT     = 16
) (
    input  logic                               i_clock,
    input  logic                               i_reset,
    input  logic [3:0]                         i_iagc_status,
    input  logic                               i_gate,
    input  logic [N_CHANNELS*NB_DECIMATOR-1:0] i_decimator,
    input  logic [1:0]                         i_mode,
    input  logic [NB_COUNT-1:0]                i_burst_len,
    output logic [N_CHANNELS-1:0]              o_sample,
    output logic [NB_COUNT-1:0]                o_sample_count,
    output logic                               o_busy,
    output logic                               o_done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [1:0] MODE_CONT    = 2'b00;
    localparam logic [1:0] MODE_GATED   = 2'b01;
    localparam logic [1:0] MODE_RESTART = 2'b10;
    localparam logic [1:0] MODE_BURST   = 2'b11;

    state_t                    state, state_nxt;
    logic                      run_q;
    logic                      gate_m, gate_s, gate_s_d;
    logic                      gate_rise;
    logic [1:0]                mode_q;
    logic [NB_DECIMATOR-1:0]   shadow [N_CHANNELS];
    logic [NB_DECIMATOR-1:0]   cnt    [N_CHANNELS];
    logic [N_CHANNELS-1:0]     wrap;
    logic [N_CHANNELS-1:0]     strobe;
    logic                      qual;
    logic                      count_en;
    logic                      burst_zero;
    logic                      burst_hit;
    logic                      restart_clr;
    logic                      trigger;
    logic [NB_COUNT-1:0]       count_nxt;
    logic                      unused_status;

    assign unused_status = ^i_iagc_status[3:2];

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            run_q    <= 1'b0;
            gate_m   <= 1'b0;
            gate_s   <= 1'b0;
            gate_s_d <= 1'b0;
        end else begin
            run_q    <= i_iagc_status[0] & i_iagc_status[1];
            gate_m   <= i_gate;
            gate_s   <= gate_m;
            gate_s_d <= gate_s;
        end
    end

    assign gate_rise   = gate_s & ~gate_s_d;
    assign burst_zero  = (mode_q == MODE_BURST) && (i_burst_len == '0);
    assign restart_clr = (state == RUN) && (mode_q == MODE_RESTART) && gate_rise;
    assign trigger     = (state == DONE) && (mode_q == MODE_BURST) && gate_rise;
    assign count_en    = run_q && (state == RUN) && qual && !burst_zero;
    assign count_nxt   = (&o_sample_count) ? o_sample_count : o_sample_count + NB_COUNT'(1);
    assign burst_hit   = (mode_q == MODE_BURST) && strobe[0] && (count_nxt == i_burst_len);
    assign o_busy      = (state == RUN);

    always_comb begin
        qual = 1'b1;
        case (mode_q)
            MODE_CONT, MODE_BURST: qual = 1'b1;
            MODE_GATED:            qual = gate_s;
            MODE_RESTART:          qual = ~gate_rise;
            default:               qual = 1'b1;
        endcase
    end

    // A zero shadow factor never matches, which keeps disabled channels silent.
    always_comb begin
        wrap   = '0;
        strobe = '0;
        for (int k = 0; k < N_CHANNELS; k++) begin
            wrap[k]   = (shadow[k] != '0) && (cnt[k] == shadow[k] - NB_DECIMATOR'(1));
            strobe[k] = count_en && wrap[k];
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (!run_q) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: state_nxt = LOAD;
                LOAD: state_nxt = (i_mode == MODE_BURST) ? DONE : RUN;
                RUN:  if (burst_zero || burst_hit) state_nxt = DONE;
                DONE: if (trigger) state_nxt = RUN;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            mode_q         <= MODE_CONT;
            o_sample       <= '0;
            o_sample_count <= '0;
            o_done         <= 1'b0;
            for (int k = 0; k < N_CHANNELS; k++) begin
                shadow[k] <= '0;
                cnt[k]    <= '0;
            end
        end else begin
            o_sample <= strobe;
            if (!run_q) begin
                o_sample_count <= '0;
                o_done         <= 1'b0;
                for (int k = 0; k < N_CHANNELS; k++) cnt[k] <= '0;
            end else begin
                case (state)
                    LOAD: begin
                        mode_q         <= i_mode;
                        o_sample_count <= '0;
                        o_done         <= 1'b0;
                        for (int k = 0; k < N_CHANNELS; k++) begin
                            shadow[k] <= i_decimator[k*NB_DECIMATOR +: NB_DECIMATOR];
                            cnt[k]    <= '0;
                        end
                    end
                    RUN: begin
                        if (burst_zero) begin
                            o_done <= 1'b1;
                        end else if (restart_clr) begin
                            o_sample_count <= '0;
                            for (int k = 0; k < N_CHANNELS; k++) cnt[k] <= '0;
                        end else if (count_en) begin
                            // New factors are only taken at a period boundary (or while disabled).
                            for (int k = 0; k < N_CHANNELS; k++) begin
                                if (shadow[k] == '0 || wrap[k]) begin
                                    cnt[k]    <= '0;
                                    shadow[k] <= i_decimator[k*NB_DECIMATOR +: NB_DECIMATOR];
                                end else begin
                                    cnt[k] <= cnt[k] + NB_DECIMATOR'(1);
                                end
                            end
                            if (strobe[0]) o_sample_count <= count_nxt;
                            if (burst_hit) o_done <= 1'b1;
                        end
                    end
                    DONE: begin
                        if (trigger) begin
                            o_sample_count <= '0;
                            o_done         <= 1'b0;
                            for (int k = 0; k < N_CHANNELS; k++) cnt[k] <= '0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_decimator_mc.sv
// Randomized bench for decimator_mc against a countdown-based behavioural model.
module tb_decimator_mc;
    localparam int NCH  = 4;
    localparam int NBD  = 8;
    localparam int NBC  = 5;
    localparam int MAXC = (1 << NBC) - 1;
    localparam int S_IDLE = 0, S_LOAD = 1, S_RUN = 2, S_DONE = 3;

    logic                 i_clock = 1'b0;
    logic                 i_reset = 1'b0;
    logic [3:0]           i_iagc_status = 4'b0000;
    logic                 i_gate = 1'b0;
    logic [NCH*NBD-1:0]   i_decimator = '0;
    logic [1:0]           i_mode = 2'b00;
    logic [NBC-1:0]       i_burst_len = '0;
    logic [NCH-1:0]       o_sample;
    logic [NBC-1:0]       o_sample_count;
    logic                 o_busy;
    logic                 o_done;

    int n_checks = 0;
    int n_fail   = 0;

    decimator_mc #(.N_CHANNELS(NCH), .NB_DECIMATOR(NBD), .NB_COUNT(NBC)) dut (
        .i_clock(i_clock), .i_reset(i_reset), .i_iagc_status(i_iagc_status),
        .i_gate(i_gate), .i_decimator(i_decimator), .i_mode(i_mode),
        .i_burst_len(i_burst_len), .o_sample(o_sample), .o_sample_count(o_sample_count),
        .o_busy(o_busy), .o_done(o_done)
    );

    always #5 i_clock = ~i_clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: each channel tracks edges remaining until its next strobe.
    int  m_st, m_mode, m_cnt;
    bit  m_runq, m_g1, m_gs, m_gsd, m_done;
    int  m_shd [NCH];
    int  m_rem [NCH];
    bit  [NCH-1:0] m_samp;

    function automatic int dec_of(int k);
        logic [NCH*NBD-1:0] d;
        d = i_decimator;
        return int'(d[k*NBD +: NBD]);
    endfunction

    task automatic model_reset();
        m_st = S_IDLE; m_mode = 0; m_cnt = 0; m_done = 0; m_samp = '0;
        m_runq = 0; m_g1 = 0; m_gs = 0; m_gsd = 0;
        for (int k = 0; k < NCH; k++) begin m_shd[k] = 0; m_rem[k] = 0; end
    endtask

    task automatic restart_periods();
        m_cnt = 0;
        for (int k = 0; k < NCH; k++) m_rem[k] = m_shd[k];
    endtask

    task automatic model_step();
        bit rise, qual;
        int nst;
        rise   = m_gs && !m_gsd;
        nst    = m_st;
        m_samp = '0;
        if (!m_runq) begin
            nst = S_IDLE; m_done = 0; m_cnt = 0;
        end else if (m_st == S_IDLE) begin
            nst = S_LOAD;
        end else if (m_st == S_LOAD) begin
            m_mode = int'(i_mode);
            for (int k = 0; k < NCH; k++) m_shd[k] = dec_of(k);
            restart_periods();
            m_done = 0;
            nst = (m_mode == 3) ? S_DONE : S_RUN;
        end else if (m_st == S_DONE) begin
            if (m_mode == 3 && rise) begin
                restart_periods(); m_done = 0; nst = S_RUN;
            end
        end else begin
            if (m_mode == 3 && i_burst_len == 0) begin
                nst = S_DONE; m_done = 1;
            end else if (m_mode == 2 && rise) begin
                restart_periods();
            end else begin
                qual = (m_mode == 1) ? m_gs : 1'b1;
                if (qual) begin
                    for (int k = 0; k < NCH; k++) begin
                        if (m_shd[k] == 0) begin
                            m_shd[k] = dec_of(k); m_rem[k] = m_shd[k];
                        end else begin
                            m_rem[k]--;
                            if (m_rem[k] == 0) begin
                                m_samp[k] = 1'b1; m_shd[k] = dec_of(k); m_rem[k] = m_shd[k];
                            end
                        end
                    end
                    if (m_samp[0] && m_cnt < MAXC) m_cnt++;
                    if (m_mode == 3 && m_samp[0] && m_cnt == int'(i_burst_len)) begin
                        nst = S_DONE; m_done = 1;
                    end
                end
            end
        end
        m_st   = nst;
        m_gsd  = m_gs;
        m_gs   = m_g1;
        m_g1   = i_gate;
        m_runq = i_iagc_status[0] & i_iagc_status[1];
    endtask

    task automatic tick();
        @(posedge i_clock);
        model_step();
        #1;
        chk("sample", 32'(o_sample), 32'(m_samp));
        chk("count", 32'(o_sample_count), 32'(m_cnt));
        chk("busy", 32'(o_busy), 32'(m_st == S_RUN));
        chk("done", 32'(o_done), 32'(m_done));
    endtask

    task automatic do_reset();
        i_reset = 1'b1;
        #1;
        chk("rst_sample", 32'(o_sample), 32'd0);
        chk("rst_count", 32'(o_sample_count), 32'd0);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_done", 32'(o_done), 32'd0);
        @(posedge i_clock);
        #1;
        i_reset = 1'b0;
        model_reset();
    endtask

    function automatic logic [NBD-1:0] rand_dec();
        int r;
        r = int'($urandom_range(0, 7));
        return (r == 7) ? NBD'(12) : NBD'(r);
    endfunction

    initial begin
        int busy_at, ch2_at, len;
        model_reset();
        #2;
        do_reset();

        // Continuous, D = {1,2,4,0}: ch2 first strobe 4 edges after LOAD.
        i_decimator   = {8'd0, 8'd4, 8'd2, 8'd1};
        i_mode        = 2'b00;
        i_iagc_status = 4'b0011;
        busy_at = -1; ch2_at = -1;
        for (int c = 0; c < 24; c++) begin
            tick();
            if (o_busy && busy_at < 0) busy_at = c;
            if (o_sample[2] && ch2_at < 0) ch2_at = c;
        end
        chk("ch2_first", 32'(ch2_at - busy_at), 32'd4);
        chk("ch2_seen", 32'(busy_at >= 0 && ch2_at >= 0), 32'd1);

        for (int seg = 0; seg < 70; seg++) begin
            i_mode      = 2'($urandom_range(0, 3));
            i_burst_len = NBC'($urandom_range(0, 4));
            for (int k = 0; k < NCH; k++) i_decimator[k*NBD +: NBD] = rand_dec();
            i_iagc_status = {2'($urandom), 2'($urandom_range(0, 2))};
            for (int c = 0; c < 3; c++) tick();
            len = int'($urandom_range(40, 160));
            for (int c = 0; c < len; c++) begin
                i_iagc_status = ($urandom_range(0, 149) == 0) ? 4'b0001 : {2'($urandom), 2'b11};
                if ($urandom_range(0, 7) == 0) i_gate = ~i_gate;
                if ($urandom_range(0, 39) == 0)
                    i_decimator[$urandom_range(0, NCH-1)*NBD +: NBD] = rand_dec();
                if ($urandom_range(0, 59) == 0) i_mode = 2'($urandom);
                if ($urandom_range(0, 49) == 0) i_burst_len = NBC'($urandom_range(0, 4));
                if ($urandom_range(0, 399) == 0) do_reset();
                tick();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
